pwm_update_scheduler: RTL and testbench

Multi-channel PWM controller for the PWM generation path. Runs from the 50 MHz system clock and derives an internal 3.125 MHz clock-enable tick (divide-by-16); it does not generate a divided clock. Several requesters share a single duty-cycle write port through round-robin arbitration. Accepted duty values are double-buffered and applied to all channels together at the next PWM period boundary.

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 73 +++++++
 rtl/pwm_update_scheduler.sv | 164 ++++++++++++++++
 tb/tb_pwm_update_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and small helpers for the PWM update scheduler and its
// round-robin arbiter.
//   DIV         clk_50M cycles per PWM tick (50 MHz / 16 = 3.125 MHz)
//   PERIOD      ticks per PWM period; duty values range 0..PERIOD
//   DUTY_W      width of a duty value
//   NUM_REQ_DEF default number of requesters sharing the write port
//   NUM_CH_DEF  default number of PWM channels
//   CH_W        channel index width for the default channel count
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int DIV         = 16;
    localparam int PERIOD      = 100;
    localparam int DUTY_W      = $clog2(PERIOD + 1);
    localparam int NUM_REQ_DEF = 4;
    localparam int NUM_CH_DEF  = 4;
    localparam int CH_W        = $clog2(NUM_CH_DEF);

    // Index width that stays at least 1 bit for single-entry structures.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    // Modular addition used for round-robin index arithmetic.
    function automatic int wrap_add(input int base, input int offset, input int modulus);
        return (base + offset) % modulus;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Reusable round-robin arbiter. The grant is combinational: it goes to the
// first asserted request at or after the pointer, scanning upward with wrap.
// When a grant is issued and advance is high, the pointer moves to the slot
// after the winner so that it has lowest priority next time.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset; also forces grant to 0
//   req      in   N request lines
//   advance  in   allows the pointer to move on a grant
//   grant    out  one-hot grant (all zero when nothing is requested)
//   ptr      out  current round-robin pointer
// -----------------------------------------------------------------------------
module rr_arbiter
    import pwm_pkg::*;
#(
    parameter int N = 4,
    localparam int PTR_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [N-1:0]     grant_c;

    always_comb begin
        int  idx;
        logic found;
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        grant_c = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        // NOTE: blocking assignments here, because found must be visible to
        // later loop iterations within the same evaluation.
        for (int off = 0; off < N; off++) begin
            idx = wrap_add(int'(ptr_q), off, N);
            if (!found && req[idx]) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                if (advance) begin
                    ptr_d = PTR_W'(wrap_add(idx, 1, N));
                end
            end
        end
        if (reset) begin
            grant_c = '0;
            ptr_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant = grant_c;
    assign ptr   = ptr_q;

endmodule

// File: rtl/pwm_update_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_update_scheduler
// Multi-channel PWM generator with a shared, round-robin arbitrated duty write
// port. Accepted duty values land in a shadow register per channel and are
// copied to the active registers of all channels together at the period
// boundary, so a channel never sees a partially updated period.
// A clock-enable tick is derived from clk_50M every DIV cycles; no divided
// clock is produced.
// Ports:
//   clk_50M       in   system clock (single domain)
//   reset         in   synchronous active-high reset
//   req_valid     in   per-requester write pending
//   req_ch        in   packed target channels, slice [i*CH_W +: CH_W]
//   req_duty      in   packed requested duties, slice [i*DUTY_W +: DUTY_W]
//   req_grant     out  one-hot grant; the write is taken on that edge
//   pwm_out       out  registered PWM outputs
//   pending       out  per-channel flag: shadow update waiting for boundary
//   period_start  out  one-cycle pulse the cycle after each boundary edge
// -----------------------------------------------------------------------------
module pwm_update_scheduler
#(
    parameter int NUM_REQ = pwm_pkg::NUM_REQ_DEF,
    parameter int NUM_CH  = pwm_pkg::NUM_CH_DEF,
    parameter int DIV     = pwm_pkg::DIV,
    parameter int PERIOD  = pwm_pkg::PERIOD,
    parameter int DUTY_W  = $clog2(PERIOD + 1),
    parameter int CH_W    = pwm_pkg::clog2_min1(NUM_CH)
) (
    input  logic                      clk_50M,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*CH_W-1:0]   req_ch,
    input  logic [NUM_REQ*DUTY_W-1:0] req_duty,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic [NUM_CH-1:0]         pending,
    output logic                      period_start
);

    import pwm_pkg::*;

    localparam int DIV_W = clog2_min1(DIV);
    localparam int PTR_W = clog2_min1(NUM_REQ);

    // ---------------------------------------------------------------- state
    logic [DIV_W-1:0]  div_cnt_q,      div_cnt_d;
    logic [DUTY_W-1:0] period_cnt_q,   period_cnt_d;
    logic [DUTY_W-1:0] shadow_q [NUM_CH];
    logic [DUTY_W-1:0] shadow_d [NUM_CH];
    logic [DUTY_W-1:0] active_q [NUM_CH];
    logic [DUTY_W-1:0] active_d [NUM_CH];
    logic [NUM_CH-1:0] pending_q,      pending_d;
    logic [NUM_CH-1:0] pwm_q,          pwm_d;
    logic              boundary_q,     boundary_d;
    logic              period_start_q, period_start_d;

    // ------------------------------------------------------------ arbitration
    logic [PTR_W-1:0]  rr_ptr;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk_50M),
        .reset   (reset),
        .req     (req_valid),
        .advance (1'b1),
        .grant   (req_grant),
        .ptr     (rr_ptr)
    );

    // Pick out the granted requester's channel and duty.
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DUTY_W-1:0] wr_duty;
    logic [DUTY_W-1:0] wr_duty_clamped;

    always_comb begin
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_duty = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i]) begin
                wr_en   = 1'b1;
                wr_ch   = req_ch[i*CH_W +: CH_W];
                wr_duty = req_duty[i*DUTY_W +: DUTY_W];
            end
        end
        wr_duty_clamped = (wr_duty > DUTY_W'(PERIOD)) ? DUTY_W'(PERIOD) : wr_duty;
    end

    // ------------------------------------------------------ next-state logic
    logic tick;
    logic boundary;

    always_comb begin
        tick     = (div_cnt_q == DIV_W'(DIV - 1));
        boundary = tick && (period_cnt_q == DUTY_W'(PERIOD - 1));

        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

        period_cnt_d = period_cnt_q;
        if (tick) begin
            period_cnt_d = boundary ? '0 : period_cnt_q + DUTY_W'(1);
        end

        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;

        // The boundary takes the shadow contents from before this edge; a
        // write granted on the same edge lands in shadow and stays pending
        // for the following boundary.
        if (boundary) begin
            active_d  = shadow_q;
            pending_d = '0;
        end

        // Channel indices outside 0..NUM_CH-1 match no entry and are dropped.
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && (wr_ch == CH_W'(c))) begin
                shadow_d[c]  = wr_duty_clamped;
                pending_d[c] = 1'b1;
            end
        end

        for (int c = 0; c < NUM_CH; c++) begin
            pwm_d[c] = (period_cnt_q < active_q[c]);
        end

        // Two stages so the pulse appears on the edge after the boundary.
        boundary_d     = boundary;
        period_start_d = boundary_q;
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            div_cnt_q      <= '0;
            period_cnt_q   <= '0;
            // NOTE: the duty arrays are reset explicitly because stale duties
            // must not survive a reset; they are small register files, not RAM.
            shadow_q       <= '{default: '0};
            active_q       <= '{default: '0};
            pending_q      <= '0;
            pwm_q          <= '0;
            boundary_q     <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            period_cnt_q   <= period_cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pwm_q          <= pwm_d;
            boundary_q     <= boundary_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign pending      = pending_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pwm_update_scheduler
// Directed bench. The channel index is widened to 3 bits so that an
// out-of-range channel (5 with four channels) can be presented.
// n counts rising edges since reset release; outputs are sampled on the
// falling edge, so "after edge n" means the state registered at edge n.
// Boundary edges fall at n = 1600, 3200, 4800, ...
// -----------------------------------------------------------------------------
module tb_pwm_update_scheduler;

    localparam int NREQ = 4;
    localparam int NCH  = 4;
    localparam int CHW  = 3;
    localparam int DW   = 7;

    logic                 clk_50M = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*CHW-1:0]  req_ch;
    logic [NREQ*DW-1:0]   req_duty;
    logic [NREQ-1:0]      req_grant;
    logic [NCH-1:0]       pwm_out;
    logic [NCH-1:0]       pending;
    logic                 period_start;

    pwm_update_scheduler #(
        .NUM_REQ (NREQ),
        .NUM_CH  (NCH),
        .DIV     (16),
        .PERIOD  (100),
        .DUTY_W  (DW),
        .CH_W    (CHW)
    ) dut (
        .clk_50M      (clk_50M),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ch       (req_ch),
        .req_duty     (req_duty),
        .req_grant    (req_grant),
        .pwm_out      (pwm_out),
        .pending      (pending),
        .period_start (period_start)
    );

    always #10 clk_50M = ~clk_50M;

    int n;
    int checks   = 0;
    int failures = 0;

    int hi_cnt   [NCH];
    int first_hi [NCH];
    int last_hi  [NCH];
    int ps_cnt, ps_first, ps_second;
    logic [NCH-1:0] pend_seen;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (n=%0d)", tag, got, exp, n);
        end
    endtask

    // One rising edge, then settle at the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk_50M);
        n++;
        @(negedge clk_50M);
    endtask

    task automatic set_req(input int i, input int ch, input int duty);
        req_ch[i*CHW +: CHW] = CHW'(ch);
        req_duty[i*DW +: DW] = DW'(duty);
    endtask

    // Run a number of cycles and record per-channel high counts/positions,
    // period_start positions and any pending bit seen.
    task automatic measure(input int cycles);
        for (int c = 0; c < NCH; c++) begin
            hi_cnt[c]   = 0;
            first_hi[c] = -1;
            last_hi[c]  = -1;
        end
        ps_cnt    = 0;
        ps_first  = -1;
        ps_second = -1;
        pend_seen = '0;
        repeat (cycles) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                if (pwm_out[c]) begin
                    hi_cnt[c]++;
                    if (first_hi[c] < 0) first_hi[c] = n;
                    last_hi[c] = n;
                end
            end
            if (period_start) begin
                ps_cnt++;
                if (ps_first < 0) ps_first = n;
                else if (ps_second < 0) ps_second = n;
            end
            pend_seen = pend_seen | pending;
        end
    endtask

    initial begin
        n         = 0;
        reset     = 1'b1;
        req_valid = '1;
        req_ch    = '0;
        req_duty  = '0;

        // ---------------- reset state (requests present must not be granted)
        repeat (3) @(posedge clk_50M);
        @(negedge clk_50M);
        check("rst_grant",   int'(req_grant),    0);
        check("rst_pwm",     int'(pwm_out),      0);
        check("rst_pending", int'(pending),      0);
        check("rst_pstart",  int'(period_start), 0);

        // ---------------- idle run: period_start at 1601 and 3201
        req_valid = '0;
        reset     = 1'b0;
        n         = 0;
        measure(3300);
        check("idle_pwm_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        check("idle_ps_cnt", ps_cnt, 2);
        check("idle_ps_1",   ps_first, 1601);
        check("idle_ps_2",   ps_second, 3201);
        check("idle_pend",   int'(pend_seen), 0);

        // ---------------- requester 0 writes ch1 = 25 mid-period
        set_req(0, 1, 25);
        req_valid = 4'b0001;
        #1;
        check("w1_grant", int'(req_grant), 4'b0001);
        step();                                     // n = 3301, write taken
        req_valid = '0;
        check("w1_pend_set", int'(pending), 4'b0010);
        measure(1498);                              // n = 4799
        check("w1_pend_hold", int'(pending), 4'b0010);
        step();                                     // n = 4800, boundary
        check("w1_pend_clr", int'(pending), 0);
        check("w1_pwm_at_bnd", int'(pwm_out[1]), 0);
        measure(1600);                              // n = 4801..6400
        check("w1_hi_cnt",  hi_cnt[1], 400);
        check("w1_first",   first_hi[1], 4801);
        check("w1_last",    last_hi[1], 5200);
        check("w1_ps",      ps_first, 4801);

        // ---------------- out-of-range channel: granted, no state change
        set_req(3, 5, 60);
        req_valid = 4'b1000;
        #1;
        check("oor_grant", int'(req_grant), 4'b1000);
        step();                                     // n = 6401, rr_ptr -> 0
        req_valid = '0;
        check("oor_pend", int'(pending), 0);

        // ---------------- all four at once with rr_ptr = 0
        set_req(0, 0, 30);
        set_req(1, 1, 100);
        set_req(2, 2, 127);
        set_req(3, 0, 0);                           // later write to ch0 wins
        req_valid = 4'b1111;
        #1;
        check("rr_g0", int'(req_grant), 4'b0001);
        step();
        req_valid = 4'b1110;
        #1;
        check("rr_g1", int'(req_grant), 4'b0010);
        step();
        req_valid = 4'b1100;
        #1;
        check("rr_g2", int'(req_grant), 4'b0100);
        step();
        req_valid = 4'b1000;
        #1;
        check("rr_g3", int'(req_grant), 4'b1000);
        step();                                     // n = 6405, rr_ptr -> 0
        req_valid = '0;
        check("rr_pend", int'(pending), 4'b0111);

        // requesters 0 and 2 again: order 0 then 2
        set_req(0, 0, 0);
        req_valid = 4'b0101;
        #1;
        check("rr2_g0", int'(req_grant), 4'b0001);
        step();
        req_valid = 4'b0100;
        #1;
        check("rr2_g2", int'(req_grant), 4'b0100);
        step();                                     // n = 6407, rr_ptr -> 3
        req_valid = '0;
        measure(1592);                              // n = 7999
        check("rr_pend_hold", int'(pending), 4'b0111);
        step();                                     // n = 8000, boundary
        check("rr_pend_clr", int'(pending), 0);
        measure(1599);                              // n = 8001..9599
        check("duty0_ch0",   hi_cnt[0], 0);
        check("duty100_ch1", hi_cnt[1], 1599);
        check("duty127_ch2", hi_cnt[2], 1599);
        check("unwritten_ch3", hi_cnt[3], 0);

        // ---------------- write ch3 = 50 granted on the boundary edge 9600
        set_req(1, 3, 50);
        req_valid = 4'b0010;                        // rr_ptr = 3 -> requester 1 wins
        #1;
        check("bnd_grant", int'(req_grant), 4'b0010);
        step();                                     // n = 9600, boundary
        req_valid = '0;
        check("bnd_pend_set", int'(pending), 4'b1000);
        measure(1599);                              // n = 9601..11199
        check("bnd_not_applied", hi_cnt[3], 0);
        check("bnd_pend_hold", int'(pending), 4'b1000);
        step();                                     // n = 11200, boundary
        check("bnd_pend_clr", int'(pending), 0);
        measure(1600);                              // n = 11201..12800
        check("bnd_hi_cnt", hi_cnt[3], 800);
        check("bnd_first",  first_hi[3], 11201);
        check("bnd_last",   last_hi[3], 12000);
        check("keep_ch0",   hi_cnt[0], 0);
        check("keep_ch1",   hi_cnt[1], 1600);
        check("keep_ch2",   hi_cnt[2], 1600);

        // ---------------- reset mid-period with a request pending
        measure(500);                               // n = 13300
        set_req(0, 2, 10);
        req_valid = 4'b0001;
        reset     = 1'b1;
        #1;
        check("mrst_grant_comb", int'(req_grant), 0);
        step();                                     // first reset edge
        check("mrst_pwm",     int'(pwm_out),      0);
        check("mrst_pending", int'(pending),      0);
        check("mrst_pstart",  int'(period_start), 0);
        check("mrst_grant",   int'(req_grant),    0);
        step();
        step();
        reset     = 1'b0;
        req_valid = '0;                             // dropped request not re-presented
        n         = 0;
        measure(1601);
        check("mrst_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        check("mrst_ps", ps_first, 1601);
        check("mrst_pend", int'(pend_seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
